// File: rtl/display_scan.sv
// display_scan: time-multiplexed 7-segment scanner for NDIG digits.
//
// One digit is selected at a time by a scan pointer that advances on each
// hz512 tick. The selected digit is shown only if it is enabled, the global
// brightness PWM is in its on-phase and, when blink support is built, it is
// not in the off-half of a blink period. Both outputs are registered.
//
// Optional feature: define DISPLAY_SCAN_BLINK_EN to build the blink logic
// (bcnt, bphase). Without it the blink port is accepted but ignored.
//
// Ports
//   ck       system clock, rising edge
//   resetn   asynchronous active-low reset
//   hz512    scan tick, one ck-cycle pulse
//   dig      digit codes, digit i at dig[4i+3:4i]
//   dispen   per-digit display enable
//   blink    per-digit blink request
//   bright   brightness, duty = (bright+1)/2^DIMW
//   common   one-hot digit select, active-high, registered
//   segment  segments a..g (MSB = a), active-high, registered
module display_scan #(
    parameter int NDIG        = 5,
    parameter int BLINK_TICKS = 256,
    parameter int DIMW        = 3
) (
    input  logic              ck,
    input  logic              resetn,
    input  logic              hz512,
    input  logic [4*NDIG-1:0] dig,
    input  logic [NDIG-1:0]   dispen,
    input  logic [NDIG-1:0]   blink,
    input  logic [DIMW-1:0]   bright,
    output logic [NDIG-1:0]   common,
    output logic [6:0]        segment
);

    logic [2:0]      ptr;
    logic [DIMW-1:0] pcnt;
    logic            pwm_on;
    logic            vis;
    logic            sel_en;
    logic [3:0]      sel_code;
    logic [NDIG-1:0] sel_hot;

    function automatic logic [6:0] segdec(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110010;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b0000001;   // '-'
            4'hB: s = 7'b0001110;   // 'L'
            4'hC: s = 7'b1001110;   // 'C'
            4'hD: s = 7'b0010101;   // 'n'
            4'hE: s = 7'b1001111;   // 'E'
            default: s = 7'b1100111; // 'P'
        endcase
        return s;
    endfunction

    // Bright = all-ones keeps pwm_on high on every pcnt value.
    assign pwm_on = (pcnt <= bright);

`ifdef DISPLAY_SCAN_BLINK_EN
    localparam int BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BCW-1:0] bcnt;
    logic           bphase;
    logic           sel_blk;

    always_ff @(posedge ck or negedge resetn) begin
        if (!resetn) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (hz512) begin
            if (bcnt == BCW'(BLINK_TICKS - 1)) begin
                bcnt   <= '0;
                bphase <= ~bphase;
            end else begin
                bcnt <= bcnt + BCW'(1);
            end
        end
    end

    always_comb begin
        sel_blk = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (ptr == 3'(i)) sel_blk = blink[i];
        end
    end

    assign vis = sel_en & pwm_on & ~(sel_blk & bphase);
`else
    logic unused_blink;
    assign unused_blink = ^blink;

    assign vis = sel_en & pwm_on;
`endif

    // Select the digit addressed by ptr; out-of-range ptr selects nothing,
    // which keeps the outputs blank rather than undefined.
    always_comb begin
        sel_en   = 1'b0;
        sel_code = 4'h0;
        sel_hot  = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (ptr == 3'(i)) begin
                sel_en     = dispen[i];
                sel_code   = dig[4*i +: 4];
                sel_hot[i] = 1'b1;
            end
        end
    end

    // Register boundary: pointer, PWM counter and both outputs.
    always_ff @(posedge ck or negedge resetn) begin
        if (!resetn) begin
            ptr     <= 3'd0;
            pcnt    <= '0;
            common  <= '0;
            segment <= 7'b0000000;
        end else begin
            pcnt <= pcnt + DIMW'(1);
            if (hz512) begin
                ptr <= (ptr == 3'(NDIG - 1)) ? 3'd0 : ptr + 3'd1;
            end
            common  <= vis ? sel_hot : '0;
            segment <= vis ? segdec(sel_code) : 7'b0000000;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

    localparam int NDIG = 5;
    localparam int BT   = 4;
    localparam int DIMW = 3;

    logic              ck;
    logic              resetn;
    logic              hz512;
    logic [4*NDIG-1:0] dig;
    logic [NDIG-1:0]   dispen;
    logic [NDIG-1:0]   blink;
    logic [DIMW-1:0]   bright;
    logic [NDIG-1:0]   common;
    logic [6:0]        segment;

    int nvec = 0;
    int nerr = 0;

    display_scan #(.NDIG(NDIG), .BLINK_TICKS(BT), .DIMW(DIMW)) dut (
        .ck      (ck),
        .resetn  (resetn),
        .hz512   (hz512),
        .dig     (dig),
        .dispen  (dispen),
        .blink   (blink),
        .bright  (bright),
        .common  (common),
        .segment (segment)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %b, want %b", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle just past the last one.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
    endtask

    // Digit i segment patterns for digits 0..4 (dig = 0x43210).
    logic [6:0] seg_tab [0:4];
    logic [6:0] let_tab [0:5];
    logic [4:0] mask_tab [0:4];

    initial begin
        logic [4:0] hot;
        int         cnt;
        int         viol;
        logic       vis;

        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
        seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011;
        let_tab[0] = 7'b0000001; let_tab[1] = 7'b0001110; let_tab[2] = 7'b1001110;
        let_tab[3] = 7'b0010101; let_tab[4] = 7'b1001111; let_tab[5] = 7'b1100111;
        mask_tab[0] = 5'b00001; mask_tab[1] = 5'b00000; mask_tab[2] = 5'b00100;
        mask_tab[3] = 5'b00000; mask_tab[4] = 5'b10000;

        resetn = 1'b0;
        hz512  = 1'b0;
        dig    = 20'h43210;
        dispen = 5'b11111;
        blink  = 5'b00000;
        bright = 3'b111;

        // 1: reset state and scan order
        cyc(3);
        chk("rst_common", 32'(common), 32'h0);
        chk("rst_segment", 32'(segment), 32'h0);
        resetn = 1'b1;
        cyc(1);
        chk("first_common", 32'(common), 32'b00001);
        chk("first_segment", 32'(segment), 32'(seg_tab[0]));
        for (int k = 1; k <= 5; k++) begin
            hz512 = 1'b1;
            cyc(1);
            hot = 5'b00001 << (k - 1);
            chk("tick_edge_common", 32'(common), 32'(hot));
            hz512 = 1'b0;
            cyc(1);
            hot = 5'b00001 << (k % 5);
            chk("scan_common", 32'(common), 32'(hot));
            chk("scan_segment", 32'(segment), 32'(seg_tab[k % 5]));
            cyc(2);
        end

        // 2: masking, ptr is back at 0
        dispen = 5'b10101;
        cyc(1);
        chk("mask_common0", 32'(common), 32'(mask_tab[0]));
        for (int k = 1; k <= 5; k++) begin
            hz512 = 1'b1;
            cyc(1);
            hz512 = 1'b0;
            cyc(1);
            chk("mask_common", 32'(common), 32'(mask_tab[k % 5]));
            chk("mask_segment", 32'(segment),
                (mask_tab[k % 5] == 5'b0) ? 32'h0 : 32'(seg_tab[k % 5]));
        end

        // 3: blink on digit 1 from a clean blink phase
        dispen = 5'b11111;
        blink  = 5'b00010;
        do_reset();
        cyc(1);
        for (int t = 1; t <= 20; t++) begin
            hz512 = 1'b1;
            cyc(1);
            hz512 = 1'b0;
            cyc(1);
`ifdef DISPLAY_SCAN_BLINK_EN
            vis = !(((t % 5) == 1) && (((t / BT) % 2) == 1));
`else
            vis = 1'b1;
`endif
            hot = vis ? (5'b00001 << (t % 5)) : 5'b00000;
            chk("blink_common", 32'(common), 32'(hot));
        end

        // 4: brightness duty with scan stopped
        blink  = 5'b00000;
        bright = 3'b010;
        cnt = 0;
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (common != 5'b0) cnt++;
            if (common == 5'b0 && segment != 7'b0) viol++;
        end
        chk("duty_010", 32'(cnt), 32'd3);
        chk("blank_seg_when_off", 32'(viol), 32'd0);
        bright = 3'b111;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (common != 5'b0) cnt++;
        end
        chk("duty_111", 32'(cnt), 32'd8);

        // 5: asynchronous reset mid-scan, then continuous ticking wraps
        do_reset();
        cyc(1);
        for (int k = 0; k < 3; k++) begin
            hz512 = 1'b1;
            cyc(1);
        end
        hz512 = 1'b0;
        cyc(1);
        chk("pre_rst_common", 32'(common), 32'b01000);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_common", 32'(common), 32'h0);
        chk("async_rst_segment", 32'(segment), 32'h0);
        cyc(1);
        resetn = 1'b1;
        cyc(1);
        chk("resume_common", 32'(common), 32'b00001);
        hz512 = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            cyc(1);
            hot = 5'b00001 << (k % 5);
            chk("wrap_common", 32'(common), 32'(hot));
        end
        hz512 = 1'b0;

        // 6: letter codes A..F in every digit
        for (int c = 0; c < 6; c++) begin
            dig = {5{4'(10 + c)}};
            cyc(1);
            chk("letter_segment", 32'(segment), 32'(let_tab[c]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/display_scan.md
# display_scan

Parametrised successor to the five-digit display driver: a time-multiplexed 7-segment scanner for `NDIG` digits with registered outputs. It adds per-digit blinking, global brightness PWM, and a defined blank segment code. It sits between the application's digit registers and the common-cathode/anode pins, and is clocked from the system clock with a one-cycle scan-tick enable.

## Interface

**Parameters**
- `NDIG`, default 5: number of digits, legal range 2..8.
- `BLINK_TICKS`, default 256: scan ticks per blink half-period, at least 1.
- `DIMW`, default 3: brightness field width, legal range 1..4.

**Ports**
- `ck`, input, 1 bit: the single system clock, rising-edge.
- `resetn`, input, 1 bit: reset, asynchronous and active-low.
- `hz512`, input, 1 bit: scan tick, one `ck`-cycle pulse.
- `dig`, input, `4*NDIG` bits: digit codes; digit *i* is `dig[4i+3:4i]`.
- `dispen`, input, `NDIG` bits: per-digit display enable.
- `blink`, input, `NDIG` bits: per-digit blink request.
- `bright`, input, `DIMW` bits: brightness; duty is (`bright`+1)/2^`DIMW`.
- `common`, output, `NDIG` bits: one-hot digit select; active-high, registered.
- `segment`, output, 7 bits: segments a..g, MSB = a; active-high, registered.

## Operation

**Scan pointer**
- `ptr` is a 3-bit register holding 0..`NDIG`-1.
- It increments on each `ck` edge where `hz512`=1, and wraps from `NDIG`-1 to 0.
- Back-to-back `hz512` pulses advance it once per cycle.

**Blink**
- `bcnt` counts `hz512` ticks.
- When `bcnt` reaches `BLINK_TICKS`-1, it clears and `bphase` toggles.

**PWM**
- `pcnt` is a `DIMW`-bit counter that increments every `ck` and wraps.
- `pwm_on` = (`pcnt` <= `bright`), so `bright`=all-ones gives 100% duty.

**Digit visibility**
- `vis` = `dispen[ptr]` & `pwm_on` & ~(`blink[ptr]` & `bphase`).

**Output registers, next state**
- `common` = `vis` ? (1 << `ptr`) : 0.
- `segment` = `vis` ? segdec(`dig[ptr]`) : 7'b0000000.

**Decoder, codes 0..F**
- 1111110, 0110000, 1101101, 1111001
- 0110011, 1011011, 1011111, 1110010
- 1111111, 1111011
- 0000001 ('-'), 0001110 ('L'), 1001110 ('C'), 0010101 ('n'), 1001111 ('E'), 1100111 ('P')

**Guarantees**
- `common` is never multi-hot.
- `segment` is never X.
- `segment` is 0 whenever `common` is 0.

## Timing

**Reset**
- `resetn`=0 asynchronously forces `ptr`=0, `bcnt`=0, `bphase`=0, `pcnt`=0, `common`=0, `segment`=0.
- Reset may assert mid-scan; outputs go to 0 immediately.

**After reset release**
- First `ck` edge: loads `common`/`segment` for digit 0, subject to `vis` with `pcnt`=0.

**Latency**
- Outputs reflect `ptr`, `pcnt`, `bphase` and inputs sampled at the previous `ck` edge, i.e. one cycle of latency.
- A `hz512` pulse at edge *n* advances `ptr`; `common` shows the new digit after edge *n*+1.

**Input changes**
- Changes on `dig`, `dispen`, `blink` or `bright` appear on the outputs one cycle later. No handshake.

**Simultaneous events**
- A `hz512` pulse at `bcnt`=`BLINK_TICKS`-1 toggles `bphase` and advances `ptr` at the same edge.

**Blink period**
- One full blink period is 2·`BLINK_TICKS` scan ticks.
- Defaults: 512 ticks, i.e. 1 s at 512 Hz.

## Configuration

- Macro: `DISPLAY_SCAN_BLINK_EN`.
- Defined: blink logic (`bcnt`, `bphase`) is built as described above.
- Undefined:
  - `bcnt` and `bphase` are absent.
  - `blink` is ignored (port retained).
  - `vis` = `dispen[ptr]` & `pwm_on`.

## Test plan

1. **Reset and scan order** (`NDIG`=5, `dispen`=11111, `bright`=111, `dig`=0x43210, pulse `hz512` every 4 cycles):
   - Zero outputs during reset.
   - `common` goes 00001→00010→00100→01000→10000→00001.
   - `segment` goes 1111110, 0110000, 1101101, 1111001, 0110011.
   - Each change lands one cycle after its tick.
2. **Masking** (`dispen`=10101): while `ptr`=1 or 3, `common`=00000 and `segment`=0000000; other digits are unaffected.
3. **Blink** (`BLINK_TICKS`=4, `blink`=00010, macro defined):
   - Digit 1 is shown for 4 ticks, then blanked for 4 ticks, repeating.
   - Other digits are never blanked.
   - With the macro undefined, digit 1 is never blanked.
4. **Brightness** (`bright`=010, `DIMW`=3, `hz512` held low): `common` is nonzero exactly 3 of every 8 cycles. With `bright`=111 it is nonzero in all 8.
5. **Reset mid-operation and wrap**:
   - Assert `resetn`=0 at `ptr`=3: `common`/`segment` go to 0 before the next `ck` edge.
   - After release, scanning resumes at digit 0.
   - Continuous `hz512`=1 wraps 4→0 with no gap cycle.
6. **Letter codes** (`dig` digit 0 = A..F in turn): `segment` = 0000001, 0001110, 1001110, 0010101, 1001111, 1100111.
